step_pulse_gen: RTL and testbench

Converts the debounced push-button level into single-cycle step pulses for the FPGA program-counter board. It sits directly downstream of the debouncer and shares that stage's slow clock-enable tick. One press yields one `step` pulse. Holding the button yields an auto-repeat pulse train after a hold delay. A wrapping pulse counter is exposed for display and debug.

---
 rtl/step_pulse_gen.sv | 135 +++++++++++++
 tb/tb_step_pulse_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_gen
// Purpose  : Debounced button level -> single-cycle step pulses, with optional
//            hold-to-auto-repeat (enabled by defining STEP_AUTOREPEAT_EN).
// Revision : 1.0  initial release
// ============================================================================
module step_pulse_gen #(
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int CW           = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       tick,
    output logic       step,
    output logic       held,
    output logic [7:0] step_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_HOLD_LAST   = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] C_REPEAT_LAST = CW'(REPEAT_TICKS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_step_nxt;
    logic       r_step;
    logic       r_held;
    logic [7:0] r_step_count;

`ifdef STEP_AUTOREPEAT_EN
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_last;

    // Terminal count depends on whether we are waiting for the first repeat.
    assign w_cnt_last = (r_state == ST_ARMED) ? C_HOLD_LAST : C_REPEAT_LAST;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn) begin
                    w_step_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED, ST_REPEAT: begin
                // Release takes priority over a coincident terminal tick.
                if (!btn) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (tick) begin
                    if (r_cnt == w_cnt_last) begin
                        w_step_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    // Single-shot build: the tick and hold/repeat timing are not used.
    logic unused_cfg;
    assign unused_cfg = ^{tick, C_HOLD_LAST, C_REPEAT_LAST};

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn) begin
                    w_step_nxt  = 1'b1;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!btn) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_step       <= 1'b0;
            r_held       <= 1'b0;
            r_step_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_held  <= (w_state_nxt != ST_IDLE);
            if (r_step) begin
                r_step_count <= r_step_count + 8'd1;
            end
        end
    end

    assign step       = r_step;
    assign held       = r_held;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_pulse_gen
// Purpose  : Directed self-checking bench for step_pulse_gen (HOLD=4, REPEAT=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_step_pulse_gen;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn   = 1'b0;
    logic       tick  = 1'b0;
    logic       step;
    logic       held;
    logic [7:0] step_count;

    int n_checks = 0;
    int n_fail   = 0;

    step_pulse_gen #(
        .HOLD_TICKS   (4),
        .REPEAT_TICKS (2),
        .CW           (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .tick       (tick),
        .step       (step),
        .held       (held),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  exp_cnt;
        int  pulses;
        bit  e;

        // Asynchronous reset, checked before any clock edge
        #3 rst_n = 1'b0;
        #1;
        check("rst_step", step, 0);
        check("rst_held", held, 0);
        check("rst_count", step_count, 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Tick toggling in IDLE must do nothing
        for (int i = 0; i < 100; i++) begin
            tick = i[0];
            cyc();
            check("idle_quiet", {step, held, step_count}, 0);
        end

        // Single short press, tick every 4th cycle
        tick = 1'b0;
        btn  = 1'b1;
        cyc();
        check("single_step0", step, 1);
        check("single_held0", held, 1);
        tick = 1'b1;
        cyc();
        check("single_step1", step, 0);
        tick = 1'b0;
        cyc();
        check("single_step2", step, 0);
        check("single_held2", held, 1);
        btn = 1'b0;
        cyc();
        check("single_step3", step, 0);
        check("single_held3", held, 0);
        cyc();
        check("single_count", step_count, 1);
        exp_cnt = 1;

        // Held button, tick every cycle: pulses at cycles 1,5,7,...,19
        tick = 1'b1;
        btn  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
`ifdef STEP_AUTOREPEAT_EN
            e = (i == 0) || (i >= 4 && (i % 2) == 0);
`else
            e = (i == 0);
`endif
            check("rpt_step", step, e);
            check("rpt_held", held, 1);
            if (e) exp_cnt++;
            if (i == 19) btn = 1'b0;
        end
        cyc();
        check("rpt_release_step", step, 0);
        check("rpt_release_held", held, 0);
        check("rpt_count", step_count, exp_cnt);

        // Release on the same edge as the terminal hold tick
        btn = 1'b1;
        cyc();
        check("col_first", step, 1);
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("col_hold_step", step, 0);
            check("col_hold_held", held, 1);
        end
        btn = 1'b0;
        cyc();
        check("col_step", step, 0);
        check("col_held", held, 0);
        cyc();
        check("col_step_after", step, 0);
        check("col_count", step_count, exp_cnt);

        // Reset mid-hold with step_count = 5, then fresh pulse on deassert
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        tick  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            btn = 1'b1;
            cyc();
            btn = 1'b0;
            cyc();
        end
        btn = 1'b1;
        cyc();
        cyc();
        cyc();
        check("mid_count5", step_count, 5);
        check("mid_held", held, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_step", step, 0);
        check("mid_rst_held", held, 0);
        check("mid_rst_count", step_count, 0);
        cyc();
        check("mid_rst_hold", held, 0);
        rst_n = 1'b1;
        cyc();
        check("mid_fresh_step", step, 1);
        check("mid_fresh_held", held, 1);
        btn = 1'b0;
        cyc();
        cyc();

        // 256 discrete presses from reset wrap the counter to zero
        rst_n = 1'b0;
        cyc();
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 256; n++) begin
            btn = 1'b1;
            cyc();
            pulses += int'(step);
            btn = 1'b0;
            cyc();
            pulses += int'(step);
            if (n == 254) check("wrap_count255", step_count, 255);
        end
        cyc();
        check("wrap_count0", step_count, 0);
        check("wrap_pulses", pulses, 256);
        check("wrap_held", held, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
